// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the five-stage pipeline.
// A single-entry WB register captures one retiring instruction per cycle,
// resolves load extraction/extension at capture time, then drives the
// register-file write port and the commit/trace interface. Commit back-pressure
// stalls the entry; a drain and a refill may happen at the same edge.
module wb_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_wen,
  input  logic [4:0]      in_wa,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  input  logic [2:0]      in_addr_low,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_mem_rdata,
  input  logic [XLEN-1:0] in_pc,
  input  logic            commit_ready,
  output logic            wen,
  output logic [4:0]      wa,
  output logic [XLEN-1:0] wd,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic [XLEN-1:0] retire_count
);

  logic            wb_valid_reg;
  logic            wen_q_reg;
  logic [4:0]      wa_q_reg;
  logic [XLEN-1:0] wd_q_reg;
  logic [XLEN-1:0] pc_q_reg;
  logic [XLEN-1:0] retire_count_reg;

  logic            fire;
  logic            accept;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] wd_next;

  // The entry retires when the commit consumer takes it; a new one may enter
  // when the register is empty or being drained this cycle.
  assign fire     = wb_valid_reg & commit_ready;
  assign in_ready = ~reset & (~wb_valid_reg | commit_ready);
  assign accept   = in_valid & in_ready;

  // Right-shift the memory word by whole bytes; lanes that would come from
  // beyond byte 7 read as zero.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [3:0] src;
      assign src = 4'(gi) + {1'b0, in_addr_low};
      assign shifted[gi*8 +: 8] = src[3] ? 8'h00 : in_mem_rdata[{src[2:0], 3'b000} +: 8];
    end
  endgenerate

  // Select ALU result or size/sign-extended load data for the capture.
  always_comb begin
    wd_next = in_alu_result;
    if (in_is_load) begin
      case (in_funct3)
        3'b000:  wd_next = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
        3'b001:  wd_next = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
        3'b010:  wd_next = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
        3'b011:  wd_next = shifted;
        3'b100:  wd_next = {{(XLEN-8){1'b0}},  shifted[7:0]};
        3'b101:  wd_next = {{(XLEN-16){1'b0}}, shifted[15:0]};
        3'b110:  wd_next = {{(XLEN-32){1'b0}}, shifted[31:0]};
        default: wd_next = '0;
      endcase
    end
  end

  // WB entry register and retire counter; accept wins over drain so a
  // simultaneous fire+accept keeps the entry valid with the new payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_reg     <= 1'b0;
      wen_q_reg        <= 1'b0;
      wa_q_reg         <= '0;
      wd_q_reg         <= '0;
      pc_q_reg         <= '0;
      retire_count_reg <= '0;
    end else begin
      if (accept) begin
        wb_valid_reg <= 1'b1;
        wen_q_reg    <= in_wen & (in_wa != 5'd0);
        wa_q_reg     <= in_wa;
        wd_q_reg     <= wd_next;
        pc_q_reg     <= in_pc;
      end else if (fire) begin
        wb_valid_reg <= 1'b0;
      end
      if (fire) begin
        retire_count_reg <= retire_count_reg + 1'b1;
      end
    end
  end

  // A write is issued only in the cycle the entry retires, never during reset.
  assign wen          = fire & wen_q_reg & ~reset;
  assign wa           = wa_q_reg;
  assign wd           = wd_q_reg;
  assign commit_valid = wb_valid_reg;
  assign commit_pc    = pc_q_reg;
  assign retire_count = retire_count_reg;

endmodule
